i2c_apb_regs: RTL and testbench

- APB slave register file and buffering stage directly upstream of the I2C controller.
- Holds slave address and control bits, and buffers transmit bytes in a TX FIFO the controller drains one byte per acknowledged write.
- Buffers received bytes in an RX FIFO, filled from the serial-to-parallel converter and read by software over APB.
- Single clock domain (core_clk); no clock crossing inside this block.

---
 rtl/i2c_apb_regs_pkg.sv | 67 ++++++
 rtl/i2c_apb_regs_if.sv | 24 ++
 rtl/i2c_sync_fifo.sv | 70 +++++++
 rtl/i2c_apb_regs.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_apb_regs.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_apb_regs_pkg.sv
// Shared definitions for the I2C APB register block.
// Contents:
//   - register byte offsets
//   - CTRL and STATUS bit indices
//   - default FIFO depth
//   - register-select enum and address decoder
//   - packed CTRL storage struct
package i2c_apb_regs_pkg;

  localparam int FIFO_DEPTH_DEF = 8;

  // Register byte offsets (paddr[1:0] is ignored by the decoder).
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_ADDR   = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_RXDATA = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  // CTRL bit indices.
  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_REP_START = 1;
  localparam int CTRL_AUTO_STOP = 2;
  localparam int CTRL_TX_CLR    = 3;
  localparam int CTRL_RX_CLR    = 4;
  localparam int CTRL_IE_TX     = 5;
  localparam int CTRL_IE_RX     = 6;

  // STATUS bit indices; TX_OVF, RX_OVF and RX_UDF are sticky.
  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_RX_UDF   = 6;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_ADDR,
    REG_TXDATA,
    REG_RXDATA,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  // Stored CTRL bits; the clear bits are pulses and are never stored.
  typedef struct packed {
    logic ie_rx;
    logic ie_tx;
    logic auto_stop;
    logic rep_start;
    logic enable;
  } ctrl_t;

  // Maps a word address (paddr[7:2]) to a register select.
  function automatic reg_sel_e decode_addr(input logic [5:0] word);
    case ({word, 2'b00})
      OFF_CTRL:   return REG_CTRL;
      OFF_ADDR:   return REG_ADDR;
      OFF_TXDATA: return REG_TXDATA;
      OFF_RXDATA: return REG_RXDATA;
      OFF_STATUS: return REG_STATUS;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_apb_regs_if.sv
// APB bus bundle for the I2C register block.
// Signals:
//   - paddr, psel, penable, pwrite, pwdata: driven by the master
//   - prdata, pready, pslverr: driven by the slave
interface i2c_apb_regs_if;
  logic [7:0] paddr;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/i2c_sync_fifo.sv
// Single-clock circular FIFO with (PTR_W+1)-bit read/write pointers.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : empties the FIFO on this edge; a same-cycle push/pop is discarded
//   push_i    : write din_i; accepted when not full, or when full with a pop
//   pop_i     : advance head; ignored on empty
//   din_i     : data to push
//   dout_o    : current head (0 when empty)
//   empty_o   : FIFO empty
//   full_o    : FIFO full
//   ovf_o     : one-cycle pulse when a push is dropped because the FIFO is full
//   count_o   : number of stored entries
module i2c_sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_o,
  output logic [PTR_W:0]   count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wptr_q, wptr_d;
  logic [PTR_W:0]   rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign count_o = wptr_q - rptr_q;

  // A pop on empty is ignored, so a push+pop on empty only pushes.
  // A pop on a full FIFO frees the slot the push writes into.
  assign pop_ok  = pop_i & ~clr_i & ~empty_o;
  assign push_ok = push_i & ~clr_i & (~full_o | pop_ok);
  assign ovf_o   = push_i & ~clr_i & full_o & ~pop_ok;

  assign wptr_d = clr_i ? '0 : wptr_q + {{PTR_W{1'b0}}, push_ok};
  assign rptr_d = clr_i ? '0 : rptr_q + {{PTR_W{1'b0}}, pop_ok};

  assign dout_o = empty_o ? '0 : mem_q[rptr_q[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, and dout_o is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[PTR_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/i2c_apb_regs.sv
// APB register file and TX/RX byte buffering in front of the I2C controller.
// Ports:
//   core_clk, rst        : clock, asynchronous active-high reset
//   apb                  : APB slave (zero wait states; pslverr on bad access)
//   enable               : CTRL.enable to controller
//   repeated_start_cond  : CTRL.repeated_start to controller
//   slave_address        : ADDR register, {addr[6:0], rw}
//   data_in              : TX FIFO head (0 when empty)
//   fifo_tx_enable       : controller pop request on TX FIFO
//   fifo_rx_enable       : converter push request on RX FIFO
//   rx_data              : byte pushed into the RX FIFO
//   irq                  : level interrupt
module i2c_apb_regs
  import i2c_apb_regs_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 core_clk,
  input  logic                 rst,
  i2c_apb_regs_if.slave        apb,
  output logic                 enable,
  output logic                 repeated_start_cond,
  output logic [7:0]           slave_address,
  output logic [7:0]           data_in,
  input  logic                 fifo_tx_enable,
  input  logic                 fifo_rx_enable,
  input  logic [7:0]           rx_data,
  output logic                 irq
);

  localparam int             PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] ONE   = 1;

  ctrl_t      ctrl_q, ctrl_d;
  logic [7:0] addr_q, addr_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       rx_ovf_q, rx_ovf_d;
  logic       rx_udf_q, rx_udf_d;

  reg_sel_e   sel;
  logic       access, wr_acc, rd_acc;
  logic       ctrl_wr, addr_wr, status_wr;
  logic       tx_push, tx_push_err, tx_clr;
  logic       rx_pop, rx_pop_err, rx_clr;
  logic       auto_stop_hit;
  logic [7:0] ctrl_rd, status_rd, rdata;

  logic [7:0]     tx_dout, rx_dout;
  logic           tx_empty, tx_full, rx_empty, rx_full;
  logic           tx_ovf_pulse, rx_ovf_pulse;
  logic [PTR_W:0] tx_count, rx_count;

  // Address low bits, pwdata[7] and the RX level carry no function here.
  logic unused_bits;
  assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[7], rx_count, tx_ovf_pulse};

  // ---------------------------------------------------------------------------
  // APB decode; all side effects happen on the access-phase edge.
  // ---------------------------------------------------------------------------
  assign sel    = decode_addr(apb.paddr[7:2]);
  assign access = apb.psel & apb.penable;
  assign wr_acc = access & apb.pwrite;
  assign rd_acc = access & ~apb.pwrite;

  assign ctrl_wr   = wr_acc & (sel == REG_CTRL);
  assign addr_wr   = wr_acc & (sel == REG_ADDR);
  assign status_wr = wr_acc & (sel == REG_STATUS);
  assign tx_clr    = ctrl_wr & apb.pwdata[CTRL_TX_CLR];
  assign rx_clr    = ctrl_wr & apb.pwdata[CTRL_RX_CLR];

  // Erroring accesses have no FIFO side effect, only the sticky flag.
  assign tx_push_err = wr_acc & (sel == REG_TXDATA) & tx_full;
  assign tx_push     = wr_acc & (sel == REG_TXDATA) & ~tx_full;
  assign rx_pop_err  = rd_acc & (sel == REG_RXDATA) & rx_empty;
  assign rx_pop      = rd_acc & (sel == REG_RXDATA) & ~rx_empty;

  assign apb.pready  = 1'b1;
  assign apb.pslverr = (access & (sel == REG_NONE)) | tx_push_err | rx_pop_err;

  // Controller pop that leaves the TX FIFO empty.
  assign auto_stop_hit = ctrl_q.auto_stop & fifo_tx_enable & ~tx_empty & ~tx_clr &
                         ~tx_push & (tx_count == ONE);

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (core_clk),
    .rst     (rst),
    .clr_i   (tx_clr),
    .push_i  (tx_push),
    .pop_i   (fifo_tx_enable),
    .din_i   (apb.pwdata),
    .dout_o  (tx_dout),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .ovf_o   (tx_ovf_pulse),
    .count_o (tx_count)
  );

  i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk     (core_clk),
    .rst     (rst),
    .clr_i   (rx_clr),
    .push_i  (fifo_rx_enable),
    .pop_i   (rx_pop),
    .din_i   (rx_data),
    .dout_o  (rx_dout),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .ovf_o   (rx_ovf_pulse),
    .count_o (rx_count)
  );

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ctrl_rd                 = '0;
    ctrl_rd[CTRL_ENABLE]    = ctrl_q.enable;
    ctrl_rd[CTRL_REP_START] = ctrl_q.rep_start;
    ctrl_rd[CTRL_AUTO_STOP] = ctrl_q.auto_stop;
    ctrl_rd[CTRL_IE_TX]     = ctrl_q.ie_tx;
    ctrl_rd[CTRL_IE_RX]     = ctrl_q.ie_rx;

    status_rd              = '0;
    status_rd[ST_TX_EMPTY] = tx_empty;
    status_rd[ST_TX_FULL]  = tx_full;
    status_rd[ST_RX_EMPTY] = rx_empty;
    status_rd[ST_RX_FULL]  = rx_full;
    status_rd[ST_TX_OVF]   = tx_ovf_q;
    status_rd[ST_RX_OVF]   = rx_ovf_q;
    status_rd[ST_RX_UDF]   = rx_udf_q;

    rdata = '0;
    if (rd_acc) begin
      case (sel)
        REG_CTRL:   rdata = ctrl_rd;
        REG_ADDR:   rdata = addr_q;
        REG_RXDATA: rdata = rx_dout;
        REG_STATUS: rdata = status_rd;
        default:    rdata = '0;
      endcase
    end
  end

  assign apb.prdata = rdata;

  // ---------------------------------------------------------------------------
  // Register next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d   = ctrl_q;
    addr_d   = addr_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    rx_udf_d = rx_udf_q;

    if (auto_stop_hit) ctrl_d.enable = 1'b0;

    // A software write on the same edge overrides the auto-stop clear.
    if (ctrl_wr) begin
      ctrl_d.enable    = apb.pwdata[CTRL_ENABLE];
      ctrl_d.rep_start = apb.pwdata[CTRL_REP_START];
      ctrl_d.auto_stop = apb.pwdata[CTRL_AUTO_STOP];
      ctrl_d.ie_tx     = apb.pwdata[CTRL_IE_TX];
      ctrl_d.ie_rx     = apb.pwdata[CTRL_IE_RX];
    end

    if (addr_wr) addr_d = apb.pwdata;

    if (status_wr) begin
      tx_ovf_d = tx_ovf_q & ~apb.pwdata[ST_TX_OVF];
      rx_ovf_d = rx_ovf_q & ~apb.pwdata[ST_RX_OVF];
      rx_udf_d = rx_udf_q & ~apb.pwdata[ST_RX_UDF];
    end

    // A new event on the same edge as a write-1-clear keeps the flag set.
    tx_ovf_d = tx_ovf_d | tx_push_err;
    rx_ovf_d = rx_ovf_d | rx_ovf_pulse;
    rx_udf_d = rx_udf_d | rx_pop_err;
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      addr_q   <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      addr_q   <= addr_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller-side outputs
  // ---------------------------------------------------------------------------
  assign enable              = ctrl_q.enable;
  assign repeated_start_cond = ctrl_q.rep_start;
  assign slave_address       = addr_q;
  assign data_in             = tx_dout;
  assign irq                 = (ctrl_q.ie_tx & tx_empty) | (ctrl_q.ie_rx & ~rx_empty);

endmodule

// File: tb/tb_i2c_apb_regs.sv
// Self-checking bench for i2c_apb_regs: directed scenarios followed by random
// APB/controller traffic, all compared against a queue-based reference model.
module tb_i2c_apb_regs;
  import i2c_apb_regs_pkg::*;

  localparam int FD = 8;

  logic       core_clk = 1'b0;
  logic       rst;
  logic       enable, repeated_start_cond, irq;
  logic [7:0] slave_address, data_in, rx_data;
  logic       fifo_tx_enable, fifo_rx_enable;

  i2c_apb_regs_if apb ();

  i2c_apb_regs #(.FIFO_DEPTH(FD)) dut (
    .core_clk            (core_clk),
    .rst                 (rst),
    .apb                 (apb),
    .enable              (enable),
    .repeated_start_cond (repeated_start_cond),
    .slave_address       (slave_address),
    .data_in             (data_in),
    .fifo_tx_enable      (fifo_tx_enable),
    .fifo_rx_enable      (fifo_rx_enable),
    .rx_data             (rx_data),
    .irq                 (irq)
  );

  always #5 core_clk = ~core_clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit         m_en, m_rs, m_as, m_ietx, m_ierx;
  bit         m_txo, m_rxo, m_rxu;
  logic [7:0] m_addr;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] obs_prdata;
  logic       obs_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_rs = 0; m_as = 0; m_ietx = 0; m_ierx = 0;
    m_txo = 0; m_rxo = 0; m_rxu = 0;
    m_addr = 8'h00;
    tx_q.delete();
    rx_q.delete();
  endtask

  function automatic logic [7:0] m_status();
    return {1'b0, m_rxu, m_rxo, m_txo,
            rx_q.size() == FD, rx_q.size() == 0,
            tx_q.size() == FD, tx_q.size() == 0};
  endfunction

  // Expected prdata/pslverr for the inputs currently on the bus.
  task automatic model_outputs(output logic [7:0] e_rd, output logic e_err);
    logic [5:0] word;
    word  = apb.paddr[7:2];
    e_rd  = 8'h00;
    e_err = 1'b0;
    if (apb.psel && apb.penable) begin
      if (word > 6'd4)                                          e_err = 1'b1;
      else if (apb.pwrite && word == 6'd2 && tx_q.size() == FD) e_err = 1'b1;
      else if (!apb.pwrite && word == 6'd3 && rx_q.size() == 0) e_err = 1'b1;
      if (!apb.pwrite) begin
        case (word)
          6'd0: e_rd = {1'b0, m_ierx, m_ietx, 2'b00, m_as, m_rs, m_en};
          6'd1: e_rd = m_addr;
          6'd3: e_rd = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
          6'd4: e_rd = m_status();
          default: e_rd = 8'h00;
        endcase
      end
    end
  endtask

  // Applies one clock edge worth of behaviour to the model.
  task automatic model_update();
    logic [5:0] word;
    bit wr, rd, ctrl_wr, txclr, rxclr, tpush, tpop, rpop, rpush, new_en;
    bit s_txo, s_rxo, s_rxu;
    if (rst) begin
      model_reset();
      return;
    end
    word    = apb.paddr[7:2];
    wr      = apb.psel && apb.penable && apb.pwrite;
    rd      = apb.psel && apb.penable && !apb.pwrite;
    ctrl_wr = wr && word == 6'd0;
    txclr   = ctrl_wr && apb.pwdata[3];
    rxclr   = ctrl_wr && apb.pwdata[4];
    new_en  = m_en;
    s_txo = 0; s_rxo = 0; s_rxu = 0;

    tpush = wr && word == 6'd2;
    if (tpush && tx_q.size() == FD) begin s_txo = 1; tpush = 0; end
    if (txclr) tx_q.delete();
    else begin
      tpop = fifo_tx_enable && tx_q.size() > 0;
      if (tpop && !tpush && tx_q.size() == 1 && m_as) new_en = 0;
      if (tpop)  void'(tx_q.pop_front());
      if (tpush) tx_q.push_back(apb.pwdata);
    end

    rpop = rd && word == 6'd3;
    if (rpop && rx_q.size() == 0) begin s_rxu = 1; rpop = 0; end
    if (rxclr) rx_q.delete();
    else begin
      rpush = fifo_rx_enable;
      if (rpush && rx_q.size() == FD && !rpop) begin s_rxo = 1; rpush = 0; end
      if (rpop)  void'(rx_q.pop_front());
      if (rpush) rx_q.push_back(rx_data);
    end

    if (wr && word == 6'd4) begin
      if (apb.pwdata[4]) m_txo = 0;
      if (apb.pwdata[5]) m_rxo = 0;
      if (apb.pwdata[6]) m_rxu = 0;
    end
    m_txo |= s_txo; m_rxo |= s_rxo; m_rxu |= s_rxu;

    if (ctrl_wr) begin
      m_en = apb.pwdata[0]; m_rs = apb.pwdata[1]; m_as = apb.pwdata[2];
      m_ietx = apb.pwdata[5]; m_ierx = apb.pwdata[6];
    end else begin
      m_en = new_en;
    end
    if (wr && word == 6'd1) m_addr = apb.pwdata;
  endtask

  // One clock: inputs are already set (just after a posedge); outputs are
  // compared at the negedge, then the model steps with the edge.
  task automatic cycle();
    logic [7:0] e_rd;
    logic       e_err;
    model_outputs(e_rd, e_err);
    @(negedge core_clk);
    obs_prdata = apb.prdata;
    obs_err    = apb.pslverr;
    check("prdata", apb.prdata, e_rd);
    check("pslverr", apb.pslverr, e_err);
    check("pready", apb.pready, 1);
    check("enable", enable, m_en);
    check("rep_start", repeated_start_cond, m_rs);
    check("slave_address", slave_address, m_addr);
    check("data_in", data_in, (tx_q.size() != 0) ? tx_q[0] : 8'h00);
    check("irq", irq, (m_ietx && tx_q.size() == 0) || (m_ierx && rx_q.size() != 0));
    model_update();
    @(posedge core_clk);
    #1;
  endtask

  task automatic apb_xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input bit ftx, input bit frx, input logic [7:0] rxd);
    apb.psel = 1; apb.penable = 0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
    cycle();
    apb.penable = 1; fifo_tx_enable = ftx; fifo_rx_enable = frx; rx_data = rxd;
    cycle();
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
    fifo_tx_enable = 0; fifo_rx_enable = 0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    apb_xfer(1, a, d, 0, 0, 8'h00);
  endtask

  task automatic apb_read(input logic [7:0] a);
    apb_xfer(0, a, 8'h00, 0, 0, 8'h00);
  endtask

  task automatic ctl(input bit ftx, input bit frx, input logic [7:0] rxd);
    fifo_tx_enable = ftx; fifo_rx_enable = frx; rx_data = rxd;
    cycle();
    fifo_tx_enable = 0; fifo_rx_enable = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals[FD];
    logic [7:0] a, d;
    int         k, kind;

    rst = 1;
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = 0; apb.pwdata = 0;
    fifo_tx_enable = 0; fifo_rx_enable = 0; rx_data = 0;
    model_reset();
    #1;
    repeat (3) cycle();
    rst = 0;
    cycle();
    check("rst_enable", enable, 0);
    check("rst_data_in", data_in, 0);
    check("rst_irq", irq, 0);

    // Status after reset, unmapped address
    apb_read(OFF_STATUS);
    check("status_reset", obs_prdata, 8'h05);
    check("status_reset_err", obs_err, 0);
    apb_read(8'h14);
    check("unmapped_err", obs_err, 1);
    check("unmapped_rd", obs_prdata, 0);

    // Address and TX head
    apb_write(OFF_ADDR, 8'hA0);
    apb_write(OFF_TXDATA, 8'h11);
    apb_write(OFF_TXDATA, 8'h22);
    check("slave_addr_a0", slave_address, 8'hA0);
    check("data_in_head", data_in, 8'h11);
    ctl(1, 0, 8'h00);
    check("data_in_after_pop", data_in, 8'h22);
    apb_write(OFF_CTRL, 8'h08);
    check("tx_clr_empty", data_in, 8'h00);
    apb_read(OFF_CTRL);
    check("ctrl_clr_reads0", obs_prdata, 8'h00);

    // TX overflow
    for (int i = 0; i < FD; i++) begin
      vals[i] = 8'($urandom);
      apb_write(OFF_TXDATA, vals[i]);
    end
    apb_write(OFF_TXDATA, 8'hEE);
    check("tx_ovf_err", obs_err, 1);
    apb_read(OFF_STATUS);
    check("status_tx_ovf", obs_prdata, 8'h16);
    apb_write(OFF_STATUS, 8'h10);
    apb_read(OFF_STATUS);
    check("status_tx_ovf_clr", obs_prdata, 8'h06);
    for (int i = 0; i < FD; i++) begin
      check("tx_contents", data_in, vals[i]);
      ctl(1, 0, 8'h00);
    end
    check("tx_drained", data_in, 8'h00);

    // Auto stop, and software write winning over it
    apb_write(OFF_TXDATA, 8'h5A);
    apb_write(OFF_CTRL, 8'h05);
    check("auto_stop_en_before", enable, 1);
    ctl(1, 0, 8'h00);
    check("auto_stop_en_after", enable, 0);
    apb_read(OFF_STATUS);
    check("auto_stop_tx_empty", obs_prdata[0], 1);
    apb_write(OFF_TXDATA, 8'h66);
    apb_xfer(1, OFF_CTRL, 8'h05, 1, 0, 8'h00);
    check("auto_stop_write_wins", enable, 1);
    check("auto_stop_write_popped", data_in, 8'h00);
    apb_write(OFF_CTRL, 8'h00);

    // RX path and underflow
    ctl(0, 1, 8'h3C);
    ctl(0, 1, 8'h7E);
    apb_read(OFF_RXDATA);
    check("rx_first", obs_prdata, 8'h3C);
    apb_read(OFF_RXDATA);
    check("rx_second", obs_prdata, 8'h7E);
    apb_read(OFF_RXDATA);
    check("rx_udf_err", obs_err, 1);
    check("rx_udf_rd", obs_prdata, 8'h00);
    apb_read(OFF_STATUS);
    check("status_rx_udf", obs_prdata, 8'h45);
    apb_write(OFF_STATUS, 8'h40);

    // RX full with simultaneous push and pop, then overflow
    for (int i = 0; i < FD; i++) begin
      vals[i] = 8'($urandom);
      ctl(0, 1, vals[i]);
    end
    apb_xfer(0, OFF_RXDATA, 8'h00, 0, 1, 8'h99);
    check("rx_full_pushpop_rd", obs_prdata, vals[0]);
    check("rx_full_pushpop_err", obs_err, 0);
    apb_read(OFF_STATUS);
    check("status_rx_full_no_ovf", obs_prdata, 8'h09);
    ctl(0, 1, 8'hAA);
    apb_read(OFF_STATUS);
    check("status_rx_ovf", obs_prdata, 8'h29);
    apb_read(OFF_RXDATA);
    check("rx_after_ovf", obs_prdata, vals[1]);
    apb_write(OFF_CTRL, 8'h10);
    apb_write(OFF_STATUS, 8'h20);

    // Interrupt enables
    apb_write(OFF_CTRL, 8'h60);
    check("irq_tx_empty", irq, 1);
    apb_write(OFF_CTRL, 8'h40);
    check("irq_rx_empty", irq, 0);
    ctl(0, 1, 8'h31);
    check("irq_rx_data", irq, 1);
    apb_write(OFF_CTRL, 8'h10);
    check("irq_off", irq, 0);

    // Random traffic
    for (int it = 0; it < 700; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        ctl($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0, 8'($urandom));
      end else begin
        k = $urandom_range(0, 9);
        if (k < 5)       a = {6'(k), 2'($urandom)};
        else if (k < 7)  a = {6'd2, 2'($urandom)};
        else if (k == 7) a = OFF_RXDATA;
        else if (k == 8) a = 8'h14;
        else             a = 8'($urandom);
        d = 8'($urandom);
        if (a[7:2] == 6'd0 && $urandom_range(0, 7) != 0) d[4:3] = 2'b00;
        apb_xfer(1'($urandom), a, d, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, 8'($urandom));
      end
    end

    // Asynchronous reset in the middle of activity
    apb_write(OFF_CTRL, 8'h03);
    apb_write(OFF_TXDATA, 8'hC3);
    apb_write(OFF_TXDATA, 8'h3C);
    ctl(0, 1, 8'h55);
    apb.psel = 1; apb.penable = 1; apb.pwrite = 0; apb.paddr = OFF_STATUS;
    #2;
    rst = 1;
    #1;
    check("arst_enable", enable, 0);
    check("arst_rep_start", repeated_start_cond, 0);
    check("arst_data_in", data_in, 8'h00);
    check("arst_status", apb.prdata, 8'h05);
    model_reset();
    apb.psel = 0; apb.penable = 0;
    @(posedge core_clk);
    #1;
    cycle();
    rst = 0;
    cycle();
    apb_read(OFF_STATUS);
    check("post_arst_status", obs_prdata, 8'h05);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
